bp_me_best_offset_prefetch_issuer: RTL and testbench

//  Consumer end of the best-offset prefetch path. Accepts the learned offset stream from
//  the best-offset generator and the demand-miss address stream. Forms the prefetch

---
 rtl/bp_me_bo_pkg.sv | 15 +
 rtl/bp_me_bo_rrt.sv | 39 +++
 rtl/bp_me_best_offset_prefetch_issuer.sv | 83 ++++++++
 tb/tb_bp_me_best_offset_prefetch_issuer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_bo_pkg.sv
// rtl/bp_me_bo_pkg.sv - shared block-address types for the best-offset prefetch path
package bp_me_bo_pkg;

  localparam int daddr_width_gp    = 64;
  localparam int lg_block_bytes_gp = 6;
  localparam int blk_width_gp      = daddr_width_gp - lg_block_bytes_gp;

  typedef logic [blk_width_gp-1:0] bo_blk_addr_t;

  typedef struct packed {
    logic         v;
    bo_blk_addr_t blk;
  } bo_rrt_entry_s;

endpackage

// File: rtl/bp_me_bo_rrt.sv
// rtl/bp_me_bo_rrt.sv - recent-request table: parallel block compare, round-robin insert
module bp_me_bo_rrt
  import bp_me_bo_pkg::*;
#(
  parameter int els_p = 8
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  bo_blk_addr_t blk_i,
  input  logic         w_v_i,
  output logic         hit_o
);

  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

  bo_rrt_entry_s       rrt_q [els_p];
  logic [lg_els_lp-1:0] ptr_q, ptr_d;

  // Lookup sees only entries committed before this cycle's insert.
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (rrt_q[i].v && (rrt_q[i].blk == blk_i)) hit_o = 1'b1;
    end
  end

  assign ptr_d = ptr_q + 1'b1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
      for (int i = 0; i < els_p; i++) rrt_q[i] <= '0;
    end else if (w_v_i) begin
      rrt_q[ptr_q] <= '{v: 1'b1, blk: blk_i};
      ptr_q        <= ptr_d;
    end
  end

endmodule

// File: rtl/bp_me_best_offset_prefetch_issuer.sv
// rtl/bp_me_best_offset_prefetch_issuer.sv - forms, filters and issues miss+offset prefetches
module bp_me_best_offset_prefetch_issuer
  import bp_me_bo_pkg::*;
#(
  parameter int daddr_width_p       = 64,
  parameter int lg_offsets_p        = 6,
  parameter int block_width_p       = 512,
  parameter int page_offset_width_p = 12,
  parameter int rrt_els_p           = 8,
  parameter int ctr_width_p         = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [lg_offsets_p-1:0]  offset_i,
  input  logic                     offset_v_i,
  output logic                     offset_yumi_o,
  input  logic [daddr_width_p-1:0] miss_addr_i,
  input  logic                     miss_v_i,
  output logic                     miss_ready_and_o,
  output logic [daddr_width_p-1:0] pf_addr_o,
  output logic                     pf_v_o,
  input  logic                     pf_ready_and_i,
  output logic [ctr_width_p-1:0]   drop_count_o
);

  localparam int lg_bb_lp  = $clog2(block_width_p / 8);
  localparam int blk_w_lp  = daddr_width_p - lg_bb_lp;
  localparam int page_lo_lp = page_offset_width_p - lg_bb_lp;

  logic [lg_offsets_p-1:0]  offset_q;
  logic                     pf_v_q, pf_v_d;
  logic [daddr_width_p-1:0] pf_addr_q, pf_addr_d;
  logic [ctr_width_p-1:0]   drop_cnt_q, drop_cnt_d;

  logic [blk_w_lp-1:0] miss_blk, cand_blk;
  logic                cand_carry, page_cross, rrt_hit;
  logic                miss_accept, drop, issue;
  logic                unused_low_bits;

  assign offset_yumi_o    = offset_v_i;
  assign miss_ready_and_o = ~pf_v_q | pf_ready_and_i;
  assign miss_accept      = miss_v_i & miss_ready_and_o;

  assign miss_blk        = miss_addr_i[daddr_width_p-1:lg_bb_lp];
  assign unused_low_bits = ^miss_addr_i[lg_bb_lp-1:0];
  assign {cand_carry, cand_blk} = {1'b0, miss_blk} + (blk_w_lp+1)'(offset_q);
  assign page_cross = cand_blk[blk_w_lp-1:page_lo_lp] != miss_blk[blk_w_lp-1:page_lo_lp];

  assign drop  = (offset_q == '0) | cand_carry | page_cross | rrt_hit;
  assign issue = miss_accept & ~drop;

  bp_me_bo_rrt #(.els_p(rrt_els_p)) rrt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .blk_i     (cand_blk),
    .w_v_i     (issue),
    .hit_o     (rrt_hit)
  );

  // An accepted miss implies the held request (if any) was taken this cycle.
  assign pf_v_d     = issue ? 1'b1 : (pf_ready_and_i ? 1'b0 : pf_v_q);
  assign pf_addr_d  = issue ? {cand_blk, {lg_bb_lp{1'b0}}} : pf_addr_q;
  assign drop_cnt_d = (miss_accept & drop & ~&drop_cnt_q) ? drop_cnt_q + 1'b1 : drop_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      offset_q   <= '0;
      pf_v_q     <= 1'b0;
      pf_addr_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (offset_v_i) offset_q <= offset_i;
      pf_v_q     <= pf_v_d;
      pf_addr_q  <= pf_addr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pf_v_o       = pf_v_q;
  assign pf_addr_o    = pf_addr_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_bp_me_best_offset_prefetch_issuer.sv
// tb/tb_bp_me_best_offset_prefetch_issuer.sv - self-checking bench for the prefetch issuer
module tb_bp_me_best_offset_prefetch_issuer;

  logic        clk;
  logic        rst_n;
  logic [5:0]  offset_i;
  logic        offset_v;
  logic        offset_yumi;
  logic [63:0] miss_addr;
  logic        miss_v;
  logic        miss_ready;
  logic [63:0] pf_addr;
  logic        pf_v;
  logic        pf_ready;
  logic [15:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  bp_me_best_offset_prefetch_issuer dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .offset_i         (offset_i),
    .offset_v_i       (offset_v),
    .offset_yumi_o    (offset_yumi),
    .miss_addr_i      (miss_addr),
    .miss_v_i         (miss_v),
    .miss_ready_and_o (miss_ready),
    .pf_addr_o        (pf_addr),
    .pf_v_o           (pf_v),
    .pf_ready_and_i   (pf_ready),
    .drop_count_o     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: offset, one held request, last 8 issued blocks, drop tally.
  logic [5:0]  m_off;
  bit          m_v;
  logic [63:0] m_addr;
  int          m_drop;
  logic [63:0] m_recent[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_off  = '0;
    m_v    = 0;
    m_addr = '0;
    m_drop = 0;
    m_recent.delete();
  endtask

  task automatic model_update();
    bit          acc;
    bit          drop;
    logic [63:0] blk;
    logic [63:0] cand;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = miss_v && (!m_v || pf_ready);
      if (acc) begin
        blk  = miss_addr >> 6;
        cand = blk + 64'(m_off);
        drop = (m_off == 0) || (cand >= 64'h0400_0000_0000_0000) || ((cand >> 6) != (blk >> 6));
        foreach (m_recent[i]) if (m_recent[i] == cand) drop = 1;
        if (drop) begin
          if (m_drop < 65535) m_drop++;
          m_v = 0;
        end else begin
          m_v    = 1;
          m_addr = cand << 6;
          m_recent.push_back(cand);
          if (m_recent.size() > 8) void'(m_recent.pop_front());
        end
      end else if (pf_ready) begin
        m_v = 0;
      end
      if (offset_v) m_off = offset_i;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    chk("pf_v", 64'(pf_v), 64'(m_v));
    if (m_v) chk("pf_addr", pf_addr, m_addr);
    chk("drop_count", 64'(drop_count), 64'(m_drop));
  endtask

  task automatic drive(input bit ov, input logic [5:0] off, input bit mv,
                       input logic [63:0] ma, input bit rdy);
    offset_v  = ov;
    offset_i  = off;
    miss_v    = mv;
    miss_addr = ma;
    pf_ready  = rdy;
    #1;
    chk("miss_ready", 64'(miss_ready), 64'(!m_v || rdy));
    chk("offset_yumi", 64'(offset_yumi), 64'(ov));
  endtask

  typedef struct {
    logic [5:0]  off;
    logic [63:0] addr;
    bit          exp_v;
    logic [63:0] exp_addr;
    int          exp_drop;
  } vec_t;

  vec_t        vecs[6];
  logic [5:0]  offs[5];
  logic [63:0] pages[3];

  initial begin
    logic [63:0] a;
    rst_n = 1'b0;
    model_reset();
    offset_v = 0; offset_i = '0; miss_v = 0; miss_addr = '0; pf_ready = 1;

    vecs[0] = '{6'd0,  64'h8000_0040,          0, 64'h0,           1};
    vecs[1] = '{6'd3,  64'h8000_0040,          1, 64'h8000_0100,   1};
    vecs[2] = '{6'd3,  64'h8000_0F80,          0, 64'h0,           2};
    vecs[3] = '{6'd63, 64'hFFFF_FFFF_FFFF_FFC0, 0, 64'h0,          3};
    vecs[4] = '{6'd1,  64'h1000,               1, 64'h1040,        3};
    vecs[5] = '{6'd1,  64'h1000,               0, 64'h0,           4};
    offs  = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd63};
    pages = '{64'h3000, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_F000};

    #3;
    chk("reset pf_v", 64'(pf_v), 64'h0);
    chk("reset pf_addr", pf_addr, 64'h0);
    chk("reset drop_count", 64'(drop_count), 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(1, vecs[i].off, 0, 64'h0, 1);
      cycle();
      drive(0, 6'd0, 1, vecs[i].addr, 1);
      cycle();
      chk($sformatf("vec%0d pf_v", i), 64'(pf_v), 64'(vecs[i].exp_v));
      if (vecs[i].exp_v) chk($sformatf("vec%0d pf_addr", i), pf_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d drop", i), 64'(drop_count), 64'(vecs[i].exp_drop));
    end

    // Identical misses on consecutive cycles: one issue, one drop.
    drive(0, 6'd0, 1, 64'h3_0000, 1);
    cycle();
    chk("b2b first issue", pf_addr, 64'h3_0040);
    drive(0, 6'd0, 1, 64'h3_0000, 1);
    cycle();
    chk("b2b second dropped", 64'(drop_count), 64'd5);
    chk("b2b pf_v low", 64'(pf_v), 64'h0);

    // Nine distinct issues evict the 0x1000 candidate from the table.
    for (int k = 0; k < 9; k++) begin
      drive(0, 6'd0, 1, 64'h2000 + 64'(k) * 64'h1000, 1);
      cycle();
      chk("stream pf_addr", pf_addr, 64'h2040 + 64'(k) * 64'h1000);
    end
    drive(0, 6'd0, 1, 64'h1000, 1);
    cycle();
    chk("evicted reissue v", 64'(pf_v), 64'h1);
    chk("evicted reissue addr", pf_addr, 64'h1040);

    // Backpressure: held request stays put, then release issues in order.
    drive(0, 6'd0, 0, 64'h0, 1);
    cycle();
    drive(0, 6'd0, 1, 64'h2_0000, 0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      drive(0, 6'd0, 1, 64'h2_1000, 0);
      chk("stall miss_ready", 64'(miss_ready), 64'h0);
      cycle();
      chk("stall pf_addr", pf_addr, 64'h2_0040);
    end
    drive(0, 6'd0, 1, 64'h2_1000, 1);
    cycle();
    chk("release 2nd", pf_addr, 64'h2_1040);
    drive(0, 6'd0, 1, 64'h2_2000, 1);
    cycle();
    chk("release 3rd", pf_addr, 64'h2_2040);
    drive(0, 6'd0, 0, 64'h0, 1);
    cycle();
    chk("drained", 64'(pf_v), 64'h0);

    // Asynchronous reset while a request is held.
    drive(0, 6'd0, 1, 64'h4_0000, 0);
    cycle();
    chk("pre-reset pf_v", 64'(pf_v), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async pf_v", 64'(pf_v), 64'h0);
    chk("async pf_addr", pf_addr, 64'h0);
    chk("async drop", 64'(drop_count), 64'h0);
    model_reset();
    drive(0, 6'd0, 0, 64'h0, 1);
    cycle();
    rst_n = 1'b1;
    drive(0, 6'd0, 1, 64'h4_0000, 1);
    cycle();
    chk("offset cleared drop", 64'(drop_count), 64'h1);
    drive(1, 6'd1, 0, 64'h0, 1);
    cycle();
    drive(0, 6'd0, 1, 64'h1000, 1);
    cycle();
    chk("rrt empty after reset", pf_addr, 64'h1040);

    for (int n = 0; n < 400; n++) begin
      a = pages[$urandom_range(0, 2)] | (64'($urandom_range(0, 63)) << 6) | 64'($urandom_range(0, 63));
      drive(($urandom_range(0, 3) == 0), offs[$urandom_range(0, 4)],
            ($urandom_range(0, 3) != 0), a, ($urandom_range(0, 2) != 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
